rtc_time_of_day: RTL and testbench

- Avalon-MM slave that keeps hours:minutes:seconds in BCD, 24-hour format, plus one minute-resolution alarm.
- Advanced by the one-second timeout from the upstream one-second interval timer, whose irq output drives sec_tick.
- Raises irq on alarm match and, optionally, on every second.
- Software (Nios) sets the time and alarm, reads them back, and clears flags over the same 16-bit/3-bit-address bus style as the timer.

---
 rtl/rtc_pkg.sv | 28 ++
 rtl/rtc_bcd2_counter.sv | 50 +++++
 rtl/rtc_time_of_day.sv | 108 ++++++++++
 tb/tb_rtc_time_of_day.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the BCD time-of-day RTC: register map, bit positions,
// BCD limits and the BCD range check used on software writes.
package rtc_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_TIME_HM  = 3'd2;
  localparam logic [2:0] ADDR_TIME_S   = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HM = 3'd4;

  localparam int ST_ALARM   = 0;
  localparam int ST_TICK    = 1;
  localparam int ST_RUNNING = 2;

  localparam int CTRL_RUN          = 0;
  localparam int CTRL_ALARM_EN     = 1;
  localparam int CTRL_ALARM_IRQ_EN = 2;
  localparam int CTRL_TICK_IRQ_EN  = 3;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_H  = 8'h23;

  // With both nibbles in 0..9, plain binary ordering matches decimal ordering.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] limit);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
  endfunction

endpackage

// File: rtl/rtc_bcd2_counter.sv
// Two-digit BCD modulo counter (0..MAX) with synchronous load that overrides inc.
module rtc_bcd2_counter #(
  parameter logic [7:0] MAX       = 8'h59,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] value_o,
  output logic [7:0] next_o,
  output logic       carry_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;
  logic [7:0] incVal;

  always_comb begin
    incVal = value_q;
    if (value_q == MAX) begin
      incVal = 8'h00;
    end else if (value_q[3:0] == 4'd9) begin
      incVal = {value_q[7:4] + 4'd1, 4'd0};
    end else begin
      incVal = {value_q[7:4], value_q[3:0] + 4'd1};
    end

    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      value_d = incVal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign next_o  = value_d;
  assign carry_o = inc_i & (value_q == MAX);

endmodule

// File: rtl/rtc_time_of_day.sv
// Avalon-MM time-of-day clock: BCD hh:mm:ss advanced by rising edges of sec_tick,
// one minute-resolution alarm, flag/irq logic and a registered read mux.
module rtc_time_of_day
  import rtc_pkg::*;
#(
  parameter logic [15:0] RESET_HM       = 16'h0000,
  parameter logic [7:0]  RESET_S        = 8'h00,
  parameter logic [15:0] RESET_ALARM_HM = 16'h0700
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sec_tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  logic        tick_q;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] alarmHm_q, alarmHm_d;
  logic        alarmFlag_q, alarmFlag_d;
  logic        tickFlag_q, tickFlag_d;
  logic [15:0] readdata_q, readdata_d;

  logic        wrEn, wrStatus, wrControl, wrTimeHm, wrTimeS, wrAlarmHm;
  logic        timeHmLoad, timeSLoad, alarmLoad;
  logic        tickEvt, advance, alarmHit;
  logic [7:0]  secVal, minVal, hourVal;
  logic [7:0]  secNext, minNext, hourNext;
  logic        secCarry, minCarry, hourCarry;

  assign wrEn      = chipselect & ~write_n;
  assign wrStatus  = wrEn & (address == ADDR_STATUS);
  assign wrControl = wrEn & (address == ADDR_CONTROL);
  assign wrTimeHm  = wrEn & (address == ADDR_TIME_HM);
  assign wrTimeS   = wrEn & (address == ADDR_TIME_S);
  assign wrAlarmHm = wrEn & (address == ADDR_ALARM_HM);

  assign timeHmLoad = wrTimeHm & bcd_valid(writedata[15:8], BCD_MAX_H)
                               & bcd_valid(writedata[7:0], BCD_MAX_MS);
  assign timeSLoad  = wrTimeS & bcd_valid(writedata[7:0], BCD_MAX_MS);
  assign alarmLoad  = wrAlarmHm & bcd_valid(writedata[15:8], BCD_MAX_H)
                                & bcd_valid(writedata[7:0], BCD_MAX_MS);

  assign tickEvt = sec_tick & ~tick_q;
  assign advance = tickEvt & ctrl_q[CTRL_RUN];

  // A seconds write replaces the value that would have carried, so its carry is dropped.
  rtc_bcd2_counter #(.MAX(BCD_MAX_MS), .RESET_VAL(RESET_S)) uSec (
    .clk_i(clk), .rst_ni(reset_n), .inc_i(advance), .load_i(timeSLoad),
    .load_val_i(writedata[7:0]), .value_o(secVal), .next_o(secNext), .carry_o(secCarry)
  );

  rtc_bcd2_counter #(.MAX(BCD_MAX_MS), .RESET_VAL(RESET_HM[7:0])) uMin (
    .clk_i(clk), .rst_ni(reset_n), .inc_i(secCarry & ~timeSLoad), .load_i(timeHmLoad),
    .load_val_i(writedata[7:0]), .value_o(minVal), .next_o(minNext), .carry_o(minCarry)
  );

  rtc_bcd2_counter #(.MAX(BCD_MAX_H), .RESET_VAL(RESET_HM[15:8])) uHour (
    .clk_i(clk), .rst_ni(reset_n), .inc_i(minCarry), .load_i(timeHmLoad),
    .load_val_i(writedata[15:8]), .value_o(hourVal), .next_o(hourNext), .carry_o(hourCarry)
  );

  assign alarmHit = advance & ctrl_q[CTRL_ALARM_EN] & ~timeHmLoad & ~timeSLoad
                  & ({hourNext, minNext, secNext} == {alarmHm_q, 8'h00});

  always_comb begin
    ctrl_d      = wrControl ? writedata[3:0] : ctrl_q;
    alarmHm_d   = alarmLoad ? writedata : alarmHm_q;
    alarmFlag_d = alarmHit | (alarmFlag_q & ~(wrStatus & writedata[ST_ALARM]));
    tickFlag_d  = advance | (tickFlag_q & ~(wrStatus & writedata[ST_TICK]));

    readdata_d = 16'h0000;
    case (address)
      ADDR_STATUS:   readdata_d = {13'd0, ctrl_q[CTRL_RUN], tickFlag_q, alarmFlag_q};
      ADDR_CONTROL:  readdata_d = {12'd0, ctrl_q};
      ADDR_TIME_HM:  readdata_d = {hourVal, minVal};
      ADDR_TIME_S:   readdata_d = {8'h00, secVal};
      ADDR_ALARM_HM: readdata_d = alarmHm_q;
      default:       readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= 1'b0;
      ctrl_q      <= 4'd0;
      alarmHm_q   <= RESET_ALARM_HM;
      alarmFlag_q <= 1'b0;
      tickFlag_q  <= 1'b0;
      readdata_q  <= 16'h0000;
    end else begin
      tick_q      <= sec_tick;
      ctrl_q      <= ctrl_d;
      alarmHm_q   <= alarmHm_d;
      alarmFlag_q <= alarmFlag_d;
      tickFlag_q  <= tickFlag_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq = (alarmFlag_q & ctrl_q[CTRL_ALARM_IRQ_EN]) | (tickFlag_q & ctrl_q[CTRL_TICK_IRQ_EN]);

endmodule

// File: tb/tb_rtc_time_of_day.sv
// Bench for rtc_time_of_day: directed scenarios plus randomized ticking checked
// against a seconds-of-day model of the clock, alarm and flags.
module tb_rtc_time_of_day;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sec_tick = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;

  int checks = 0;
  int passed = 0;

  int         mTime;
  int         mAlarm;
  logic [3:0] mCtrl;
  logic       mAlarmFlag;
  logic       mTickFlag;

  rtc_time_of_day dut (
    .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic bit bcdOk(input logic [7:0] v, input int maxDec);
    return (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9) && (int'(v[7:4]) * 10 + int'(v[3:0]) <= maxDec);
  endfunction

  function automatic int bcdDec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] expHm();
    return {toBcd(mTime / 3600), toBcd((mTime / 60) % 60)};
  endfunction

  function automatic logic [15:0] expS();
    return {8'h00, toBcd(mTime % 60)};
  endfunction

  function automatic logic [15:0] expStatus();
    return {13'd0, mCtrl[0], mTickFlag, mAlarmFlag};
  endfunction

  function automatic logic expIrq();
    return (mAlarmFlag & mCtrl[2]) | (mTickFlag & mCtrl[3]);
  endfunction

  task automatic modelReset();
    mTime = 0;
    mAlarm = 7 * 60;
    mCtrl = 4'd0;
    mAlarmFlag = 1'b0;
    mTickFlag = 1'b0;
  endtask

  task automatic modelWrite(input logic [2:0] addr, input logic [15:0] d);
    case (addr)
      3'd0: begin
        if (d[0]) mAlarmFlag = 1'b0;
        if (d[1]) mTickFlag = 1'b0;
      end
      3'd1: mCtrl = d[3:0];
      3'd2: if (bcdOk(d[15:8], 23) && bcdOk(d[7:0], 59))
              mTime = bcdDec(d[15:8]) * 3600 + bcdDec(d[7:0]) * 60 + mTime % 60;
      3'd3: if (bcdOk(d[7:0], 59))
              mTime = mTime - mTime % 60 + bcdDec(d[7:0]);
      3'd4: if (bcdOk(d[15:8], 23) && bcdOk(d[7:0], 59))
              mAlarm = bcdDec(d[15:8]) * 60 + bcdDec(d[7:0]);
      default: ;
    endcase
  endtask

  task automatic modelAdvance();
    mTime = (mTime + 1) % 86400;
    mTickFlag = 1'b1;
    if (mCtrl[1] && (mTime % 60 == 0) && (mTime / 60 == mAlarm)) mAlarmFlag = 1'b1;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [15:0] d);
    @(negedge clk);
    address = addr;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    modelWrite(addr, d);
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [15:0] d);
    @(negedge clk);
    address = addr;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic pulseTick(input int hold, input int gap);
    @(negedge clk);
    sec_tick = 1'b1;
    repeat (hold) @(negedge clk);
    sec_tick = 1'b0;
    if (mCtrl[0]) modelAdvance();
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    logic [15:0] want [8];
    want = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0700, 16'h0000, 16'h0000, 16'h0000};
    modelReset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 16'h0000 || irq !== 1'b0)
      $display("[TB] FAIL reset_outputs: readdata=%h irq=%b want 0000/0", readdata, irq);
    else passed++;
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), rd);
      checks++;
      if (rd !== want[a]) $display("[TB] FAIL reset_reg%0d: got %h want %h", a, rd, want[a]);
      else passed++;
    end
  endtask

  task automatic test_rollover();
    logic [15:0] rd;
    busWrite(3'd2, 16'h2359);
    busWrite(3'd3, 16'h0059);
    busWrite(3'd1, 16'h0001);
    pulseTick(1, 1);
    readReg(3'd2, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL rollover_hm: got %h want 0000", rd); else passed++;
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL rollover_s: got %h want 0000", rd); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0006) $display("[TB] FAIL rollover_status: got %h want 0006", rd); else passed++;
    busWrite(3'd0, 16'h0003);
  endtask

  task automatic test_alarm();
    logic [15:0] rd;
    busWrite(3'd4, 16'h0700);
    busWrite(3'd2, 16'h0659);
    busWrite(3'd3, 16'h0059);
    busWrite(3'd1, 16'h0007);
    pulseTick(1, 0);
    checks++;
    if (irq !== 1'b1) $display("[TB] FAIL alarm_irq_set: got %b want 1", irq); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0007) $display("[TB] FAIL alarm_status: got %h want 0007", rd); else passed++;
    busWrite(3'd0, 16'h0001);
    checks++;
    if (irq !== 1'b0) $display("[TB] FAIL alarm_irq_clear: got %b want 0", irq); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0006) $display("[TB] FAIL alarm_status_clear: got %h want 0006", rd); else passed++;
  endtask

  task automatic test_invalid();
    logic [15:0] rd;
    logic [15:0] badHm [3];
    badHm = '{16'h2400, 16'h1A00, 16'h0960};
    busWrite(3'd1, 16'h0000);
    busWrite(3'd2, 16'h0815);
    busWrite(3'd3, 16'h0042);
    for (int i = 0; i < 3; i++) begin
      busWrite(3'd2, badHm[i]);
      readReg(3'd2, rd);
      checks++;
      if (rd !== 16'h0815) $display("[TB] FAIL invalid_hm_%h: got %h want 0815", badHm[i], rd);
      else passed++;
    end
    busWrite(3'd3, 16'h0060);
    busWrite(3'd3, 16'h004A);
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0042) $display("[TB] FAIL invalid_s: got %h want 0042", rd); else passed++;
    busWrite(3'd4, 16'h2400);
    readReg(3'd4, rd);
    checks++;
    if (rd !== 16'h0700) $display("[TB] FAIL invalid_alarm: got %h want 0700", rd); else passed++;
    busWrite(3'd4, 16'h2359);
    readReg(3'd4, rd);
    checks++;
    if (rd !== 16'h2359) $display("[TB] FAIL valid_alarm_max: got %h want 2359", rd); else passed++;
    busWrite(3'd5, 16'hFFFF);
    readReg(3'd5, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL unmapped_read: got %h want 0000", rd); else passed++;
    readReg(3'd1, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL unmapped_write_ctrl: got %h want 0000", rd); else passed++;
  endtask

  task automatic test_held_level();
    logic [15:0] rd;
    busWrite(3'd0, 16'h0003);
    busWrite(3'd1, 16'h0001);
    busWrite(3'd2, 16'h1000);
    busWrite(3'd3, 16'h0000);
    @(negedge clk);
    sec_tick = 1'b1;
    repeat (100) @(negedge clk);
    sec_tick = 1'b0;
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0001) $display("[TB] FAIL held_level_s: got %h want 0001", rd); else passed++;
    busWrite(3'd1, 16'h0000);
    busWrite(3'd0, 16'h0003);
    for (int i = 0; i < 5; i++) pulseTick(1, 1);
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0001) $display("[TB] FAIL run_off_s: got %h want 0001", rd); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL run_off_status: got %h want 0000", rd); else passed++;
    @(negedge clk);
    sec_tick = 1'b1;
    busWrite(3'd1, 16'h0001);
    repeat (4) @(negedge clk);
    sec_tick = 1'b0;
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0001) $display("[TB] FAIL run_on_high_s: got %h want 0001", rd); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0004) $display("[TB] FAIL run_on_high_status: got %h want 0004", rd); else passed++;
  endtask

  task automatic collide(input logic [2:0] addr, input logic [15:0] d);
    @(negedge clk);
    sec_tick = 1'b1;
    address = addr;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    sec_tick = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_collision();
    logic [15:0] rd;
    busWrite(3'd1, 16'h0003);
    busWrite(3'd4, 16'h1235);
    busWrite(3'd2, 16'h1234);
    busWrite(3'd3, 16'h0059);
    busWrite(3'd0, 16'h0003);
    collide(3'd3, 16'h0030);
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0030) $display("[TB] FAIL collide_s_s: got %h want 0030", rd); else passed++;
    readReg(3'd2, rd);
    checks++;
    if (rd !== 16'h1234) $display("[TB] FAIL collide_s_hm: got %h want 1234", rd); else passed++;
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0006) $display("[TB] FAIL collide_s_status: got %h want 0006", rd); else passed++;

    busWrite(3'd2, 16'h1111);
    busWrite(3'd3, 16'h0059);
    collide(3'd2, 16'h0800);
    readReg(3'd2, rd);
    checks++;
    if (rd !== 16'h0800) $display("[TB] FAIL collide_hm_hm: got %h want 0800", rd); else passed++;
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL collide_hm_s: got %h want 0000", rd); else passed++;

    busWrite(3'd4, 16'h0801);
    busWrite(3'd2, 16'h0800);
    busWrite(3'd3, 16'h0059);
    busWrite(3'd0, 16'h0003);
    collide(3'd0, 16'h0003);
    readReg(3'd0, rd);
    checks++;
    if (rd !== 16'h0007) $display("[TB] FAIL set_beats_clear: got %h want 0007", rd); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] rd;
    int start;
    int n;
    for (int r = 0; r < 8; r++) begin
      busWrite(3'd1, {12'd0, 3'($urandom_range(0, 7)), 1'b1});
      n = $urandom_range(0, 1439);
      busWrite(3'd4, {toBcd(n / 60), toBcd(n % 60)});
      if (r == 0) start = 86400 - 30;
      else start = (mAlarm * 60 - $urandom_range(0, 90) + 86400) % 86400;
      busWrite(3'd2, {toBcd(start / 3600), toBcd((start / 60) % 60)});
      busWrite(3'd3, {8'h00, toBcd(start % 60)});
      busWrite(3'd0, 16'h0003);
      if ($urandom_range(0, 1) == 1) busWrite(3'd3, 16'($urandom));
      n = $urandom_range(5, 100);
      for (int i = 0; i < n; i++) pulseTick($urandom_range(1, 3), $urandom_range(0, 2));
      checks++;
      if (irq !== expIrq()) $display("[TB] FAIL rand%0d_irq: got %b want %b", r, irq, expIrq());
      else passed++;
      readReg(3'd2, rd);
      checks++;
      if (rd !== expHm()) $display("[TB] FAIL rand%0d_hm: got %h want %h", r, rd, expHm());
      else passed++;
      readReg(3'd3, rd);
      checks++;
      if (rd !== expS()) $display("[TB] FAIL rand%0d_s: got %h want %h", r, rd, expS());
      else passed++;
      readReg(3'd0, rd);
      checks++;
      if (rd !== expStatus()) $display("[TB] FAIL rand%0d_status: got %h want %h", r, rd, expStatus());
      else passed++;
      busWrite(3'd0, 16'($urandom_range(0, 3)));
      readReg(3'd0, rd);
      checks++;
      if (rd !== expStatus()) $display("[TB] FAIL rand%0d_clear: got %h want %h", r, rd, expStatus());
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] rd;
    busWrite(3'd1, 16'h0009);
    busWrite(3'd2, 16'h1234);
    pulseTick(1, 0);
    readReg(3'd2, rd);
    checks++;
    if (rd !== 16'h1234 || irq !== 1'b1)
      $display("[TB] FAIL areset_pre: readdata=%h irq=%b want 1234/1", rd, irq);
    else passed++;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 16'h0000 || irq !== 1'b0)
      $display("[TB] FAIL areset_immediate: readdata=%h irq=%b want 0000/0", readdata, irq);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    readReg(3'd2, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL areset_hm: got %h want 0000", rd); else passed++;
    readReg(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL areset_s: got %h want 0000", rd); else passed++;
    readReg(3'd1, rd);
    checks++;
    if (rd !== 16'h0000) $display("[TB] FAIL areset_ctrl: got %h want 0000", rd); else passed++;
    readReg(3'd4, rd);
    checks++;
    if (rd !== 16'h0700) $display("[TB] FAIL areset_alarm: got %h want 0700", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_alarm();
    test_invalid();
    test_held_level();
    test_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
